alarm_clock_ctrl: RTL
=====================

// Module: alarm_clock_ctrl
// PURPOSE
//   Timekeeping and alarm sequencer for the alarm clock. Keeps 24-hour time
//   (hh:mm:ss) from a clock-cycle prescaler, runs the set-time/set-alarm mode
//   FSM from debounced buttons, and drives the raw 0..23 hour into the
//   downstream 12/24-hour display decoder. Owns alarm match, ring, snooze and
//   ring timeout.
// PARAMETERS
//   TICKS_PER_SEC  100_000_000  clk cycles per second; must be >= 2
//   SNOOZE_MIN     5            snooze delay in minutes, 1..59
//   RING_MIN       1            auto-stop after this many minutes ringing, 1..59
// PORTS
//   clk            in   1  system clock; the only clock
//   rst_n          in   1  reset, synchronous, active-low
//   mode_btn       in   1  one-cycle pulse, advances mode FSM
//   inc_btn        in   1  one-cycle pulse, increments field being set
//   snooze_btn     in   1  one-cycle pulse, snooze while ringing
//   stop_btn       in   1  one-cycle pulse, stops ring, cancels snooze
//   alarm_en       in   1  level; 0 disables alarm, clears ring and snooze
//   disp_hour      out  6  hour to display decoder, 0..23
//   disp_min       out  6  minute to display, 0..59
//   second         out  6  current seconds, 0..59
//   mode           out  3  0 RUN,1 SET_TIME_H,2 SET_TIME_M,3 SET_ALM_H,4 SET_ALM_M
//   sec_tick       out  1  one-cycle pulse per second
//   alarm_ringing  out  1  level, alarm sounding
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): time 00:00:00, alarm 00:00, prescaler 0,
//     mode RUN, sec_tick 0, alarm_ringing 0, snooze pending cleared.
//   All outputs registered. Buttons are pulses, sampled at the clk edge.
//   Prescaler: counts 0..TICKS_PER_SEC-1, wraps; sec_tick=1 for the cycle it
//     equals TICKS_PER_SEC-1. Time regs update on the edge ending that cycle.
//   Carry: ss 59->0 incs mm; mm 59->0 incs hh; hh 23->0. No other hour values.
//   FSM: mode_btn cycles RUN->SET_TIME_H->SET_TIME_M->SET_ALM_H->SET_ALM_M->RUN.
//   SET_TIME_*: prescaler held at 0, time frozen, sec_tick 0; inc_btn adds 1
//     to hh (mod 24) or mm (mod 60). Exit from SET_TIME_M zeroes seconds.
//   SET_ALM_*: time keeps running; inc_btn adds 1 to alarm hh/mm (mod 24/60).
//   RUN: inc_btn ignored.
//   mode_btn and inc_btn same cycle: mode advances, inc ignored.
//   disp_hour/disp_min: alarm values in SET_ALM_*, else current time.
//   Match: when time regs become hh:mm:00 equal to alarm (or snooze target),
//     alarm_en=1 and mode not SET_TIME_*, alarm_ringing=1 from next cycle.
//   Match with alarm setpoint also clears any pending snooze.
//   While ringing: ring_cnt counts sec_ticks; at RING_MIN*60 ring clears,
//     no snooze armed.
//   snooze_btn while ringing: ring clears next cycle; snooze target =
//     current hh:mm + SNOOZE_MIN (mod 24h); pending flag set.
//   stop_btn: clears ring and pending snooze. stop+snooze same cycle: stop wins.
//   snooze_btn/stop_btn while not ringing: stop clears pending snooze only;
//     snooze ignored.
//   alarm_en=0: ring and pending snooze cleared next cycle; no new match.
//   Ring survives mode changes except entry to SET_TIME_H clears it.
//   Reset mid-operation (any state, ringing, mid-prescale): full reset values.
// TESTING (TICKS_PER_SEC=4, SNOOZE_MIN=5, RING_MIN=1)
//   Rollover: set time 23:59, run 60 s -> 00:00:00 on the tick, sec_tick 1/4 cycles.
//   Set mode: from RUN, mode x1, inc x13 -> disp_hour 13; mode, inc x2 -> 13:02,
//     time frozen; mode -> seconds 0, running.
//   Alarm: alarm 07:30, time 07:29:58, en=1 -> ringing 1 cycle after 07:30:00;
//     no stop -> clears at 07:31:00.
//   Snooze: ringing at 07:30:03, snooze -> ring 0; re-rings after 07:35:00;
//     stop+snooze same cycle -> ring 0, no re-ring at 07:40.
//   Edge: alarm 00:00 at 23:59:59 -> rings after 00:00:00; alarm_en=0 while
//     ringing -> ring 0 next cycle.
//   Reset: assert rst_n=0 while ringing in SET_ALM_M -> 00:00:00, mode 0, ring 0.

Source files
------------

// File: rtl/alarm_clock_ctrl.sv
// alarm_clock_ctrl: 24-hour timekeeper with a set-time/set-alarm mode FSM, alarm match, ring, snooze and ring timeout.
// Latency: every output is registered. A button pulse takes effect on the clk edge that samples it, and a match rings one cycle after the time reaches hh:mm:00.
// Backpressure: none. Buttons are single-cycle pulses that are always accepted, and a prescaler tick is never dropped.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   mode_btn, inc_btn  : advance the mode FSM / increment the field being set
//   snooze_btn,stop_btn: snooze or stop the ring
//   alarm_en           : level; 0 disables the alarm and clears ring and snooze
//   disp_hour/disp_min : raw 0..23 hour and minute for the display (alarm values while setting the alarm)
//   second, mode       : current seconds, mode FSM state
//   sec_tick           : one-cycle pulse per second
//   alarm_ringing      : alarm sounding
module alarm_clock_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_MIN      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  input  logic       alarm_en,
  output logic [5:0] disp_hour,
  output logic [5:0] disp_min,
  output logic [5:0] second,
  output logic [2:0] mode,
  output logic       sec_tick,
  output logic       alarm_ringing
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam int RING_TICKS = RING_MIN * 60;
  localparam int RW = $clog2(RING_TICKS);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 1);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_TIME_H = 3'd1,
    SET_TIME_M = 3'd2,
    SET_ALM_H  = 3'd3,
    SET_ALM_M  = 3'd4
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [5:0]      alm_h_q, alm_h_d, alm_m_q, alm_m_d;
  logic [5:0]      snz_h_q, snz_h_d, snz_m_q, snz_m_d;
  logic            snz_pend_q, snz_pend_d;
  logic            ring_q, ring_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic            tick_q, tick_d;
  logic            adv_q, adv_d;   // time regs advanced on the previous edge
  logic [5:0]      disp_h_q, disp_h_d, disp_m_q, disp_m_d;

  logic            set_time_now, set_time_next, at_min, alm_hit, snz_hit;
  logic [6:0]      snz_sum;

  function automatic logic [5:0] inc_mod(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  // Mode FSM next state; mode_btn takes priority over inc_btn.
  always_comb begin
    mode_d = mode_q;
    if (mode_btn) begin
      case (mode_q)
        RUN:        mode_d = SET_TIME_H;
        SET_TIME_H: mode_d = SET_TIME_M;
        SET_TIME_M: mode_d = SET_ALM_H;
        SET_ALM_H:  mode_d = SET_ALM_M;
        default:    mode_d = RUN;
      endcase
    end
  end

  always_comb begin
    hh_d = hh_q; mm_d = mm_q; ss_d = ss_q;
    alm_h_d = alm_h_q; alm_m_d = alm_m_q;
    snz_h_d = snz_h_q; snz_m_d = snz_m_q; snz_pend_d = snz_pend_q;
    ring_d = ring_q; ring_cnt_d = ring_cnt_q;

    set_time_now  = (mode_q == SET_TIME_H) || (mode_q == SET_TIME_M);
    set_time_next = (mode_d == SET_TIME_H) || (mode_d == SET_TIME_M);

    // Prescaler stays at 0 while time is being set and for the first cycle
    // after leaving, so the first second after exit is a full second.
    if (set_time_now || set_time_next) presc_d = '0;
    else if (presc_q == PRESC_MAX)     presc_d = '0;
    else                               presc_d = presc_q + PW'(1);
    tick_d = (presc_d == PRESC_MAX);
    adv_d  = tick_q;

    if (tick_q) begin
      ss_d = inc_mod(ss_q, 6'd59);
      if (ss_q == 6'd59) begin
        mm_d = inc_mod(mm_q, 6'd59);
        if (mm_q == 6'd59) hh_d = inc_mod(hh_q, 6'd23);
      end
    end

    if (inc_btn && !mode_btn) begin
      case (mode_q)
        SET_TIME_H: hh_d    = inc_mod(hh_q, 6'd23);
        SET_TIME_M: mm_d    = inc_mod(mm_q, 6'd59);
        SET_ALM_H:  alm_h_d = inc_mod(alm_h_q, 6'd23);
        SET_ALM_M:  alm_m_d = inc_mod(alm_m_q, 6'd59);
        default: ;
      endcase
    end
    if (mode_q == SET_TIME_M && mode_d != SET_TIME_M) ss_d = 6'd0;

    // Only a tick that lands exactly on hh:mm:00 can match.
    at_min  = adv_q && (ss_q == 6'd0) && alarm_en && !set_time_now;
    alm_hit = at_min && (hh_q == alm_h_q) && (mm_q == alm_m_q);
    snz_hit = at_min && snz_pend_q && (hh_q == snz_h_q) && (mm_q == snz_m_q);

    snz_sum = {1'b0, mm_q} + 7'(SNOOZE_MIN);

    if (ring_q && tick_q) begin
      if (ring_cnt_q == RING_LAST) begin
        ring_d     = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RW'(1);
      end
    end
    if (alm_hit || snz_hit) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
      snz_pend_d = 1'b0;
    end
    if (snooze_btn && ring_q && !stop_btn) begin
      ring_d     = 1'b0;
      snz_pend_d = 1'b1;
      if (snz_sum >= 7'd60) begin
        snz_m_d = 6'(snz_sum - 7'd60);
        snz_h_d = inc_mod(hh_q, 6'd23);
      end else begin
        snz_m_d = snz_sum[5:0];
        snz_h_d = hh_q;
      end
    end
    if (stop_btn) begin
      ring_d     = 1'b0;
      snz_pend_d = 1'b0;
    end
    if (mode_q != SET_TIME_H && mode_d == SET_TIME_H) ring_d = 1'b0;
    if (!alarm_en) begin
      ring_d     = 1'b0;
      snz_pend_d = 1'b0;
    end

    if (mode_d == SET_ALM_H || mode_d == SET_ALM_M) begin
      disp_h_d = alm_h_d;
      disp_m_d = alm_m_d;
    end else begin
      disp_h_d = hh_d;
      disp_m_d = mm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= RUN;        presc_q <= '0;
      hh_q <= '0;           mm_q <= '0;       ss_q <= '0;
      alm_h_q <= '0;        alm_m_q <= '0;
      snz_h_q <= '0;        snz_m_q <= '0;    snz_pend_q <= 1'b0;
      ring_q <= 1'b0;       ring_cnt_q <= '0;
      tick_q <= 1'b0;       adv_q <= 1'b0;
      disp_h_q <= '0;       disp_m_q <= '0;
    end else begin
      mode_q <= mode_d;     presc_q <= presc_d;
      hh_q <= hh_d;         mm_q <= mm_d;     ss_q <= ss_d;
      alm_h_q <= alm_h_d;   alm_m_q <= alm_m_d;
      snz_h_q <= snz_h_d;   snz_m_q <= snz_m_d; snz_pend_q <= snz_pend_d;
      ring_q <= ring_d;     ring_cnt_q <= ring_cnt_d;
      tick_q <= tick_d;     adv_q <= adv_d;
      disp_h_q <= disp_h_d; disp_m_q <= disp_m_d;
    end
  end

  assign disp_hour     = disp_h_q;
  assign disp_min      = disp_m_q;
  assign second        = ss_q;
  assign mode          = mode_q;
  assign sec_tick      = tick_q;
  assign alarm_ringing = ring_q;

endmodule
